// File: rtl/rlgl_race_core.sv
// Red-light/green-light race engine: synchronised click inputs, timed or
// manual light phases, per-player position counters, leader and winner.
module rlgl_race_core #(
    parameter int NUM_PLAYERS  = 4,
    parameter int POS_W        = 4,
    parameter int PID_W        = 2,
    parameter int GREEN_CYC    = 1000,
    parameter int RED_CYC      = 500,
    parameter int PENALTY_MODE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PLAYERS-1:0]       click,
    input  logic                         start,
    input  logic [POS_W-1:0]             max_clicks,
    input  logic                         auto_light,
    input  logic                         red_toggle,
    output logic [NUM_PLAYERS*POS_W-1:0] positions,
    output logic [1:0]                   light,
    output logic [PID_W-1:0]             leader,
    output logic                         winner_valid,
    output logic [PID_W-1:0]             winner_id,
    output logic [1:0]                   game_state
);

    localparam int TMAX  = (GREEN_CYC > RED_CYC) ? GREEN_CYC : RED_CYC;
    localparam int TMR_W = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GREEN = 2'b01,
        S_RED   = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t                 state_q, state_d;
    logic [POS_W-1:0]       pos_q [NUM_PLAYERS];
    logic [POS_W-1:0]       pos_d [NUM_PLAYERS];
    logic [POS_W-1:0]       target_q, target_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [PID_W-1:0]       leader_q, leader_d;
    logic                   win_valid_q, win_valid_d;
    logic [PID_W-1:0]       win_id_q, win_id_d;
    logic                   auto_q, auto_d;

    logic [NUM_PLAYERS-1:0] click_s1_q, click_s1_d;
    logic [NUM_PLAYERS-1:0] click_s2_q, click_s2_d;
    logic [NUM_PLAYERS-1:0] click_e_q, click_e_d;
    logic                   tog_s1_q, tog_s1_d;
    logic                   tog_s2_q, tog_s2_d;
    logic                   tog_e_q, tog_e_d;

    logic [NUM_PLAYERS-1:0] press;
    logic                   tog_press;
    logic                   hit;
    logic [PID_W-1:0]       hit_id;
    logic [POS_W-1:0]       best;

    always_comb begin
        click_s1_d = click;
        click_s2_d = click_s1_q;
        click_e_d  = click_s2_q;
        tog_s1_d   = red_toggle;
        tog_s2_d   = tog_s1_q;
        tog_e_d    = tog_s2_q;
        auto_d     = auto_light;
        press      = click_s2_q & ~click_e_q;
        tog_press  = tog_s2_q & ~tog_e_q;
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        target_d    = target_q;
        timer_d     = timer_q;
        win_valid_d = win_valid_q;
        win_id_d    = win_id_q;
        hit         = 1'b0;
        hit_id      = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        pos_d[i] = '0;
                    end
                    target_d    = (max_clicks == '0) ? POS_W'(1) : max_clicks;
                    timer_d     = '0;
                    win_valid_d = 1'b0;
                    win_id_d    = '0;
                    state_d     = S_GREEN;
                end
            end
            default: begin
                // Penalty decisions use the light as it is this cycle.
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (press[i]) begin
                        if (state_q == S_GREEN) begin
                            if (pos_q[i] != target_q) begin
                                pos_d[i] = pos_q[i] + POS_W'(1);
                            end
                        end else if (PENALTY_MODE == 1) begin
                            pos_d[i] = '0;
                        end else if (PENALTY_MODE == 2) begin
                            if (pos_q[i] != '0) begin
                                pos_d[i] = pos_q[i] - POS_W'(1);
                            end
                        end
                    end
                end
                if (auto_q) begin
                    if (state_q == S_GREEN &&
                        timer_q == TMR_W'(GREEN_CYC - 1)) begin
                        state_d = S_RED;
                        timer_d = '0;
                    end else if (state_q == S_RED &&
                                 timer_q == TMR_W'(RED_CYC - 1)) begin
                        state_d = S_GREEN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end else begin
                    timer_d = '0;
                    if (tog_press) begin
                        state_d = (state_q == S_GREEN) ? S_RED : S_GREEN;
                    end
                end
                // Descending scan leaves the lowest matching index.
                for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
                    if (pos_d[i] == target_q) begin
                        hit    = 1'b1;
                        hit_id = PID_W'(i);
                    end
                end
                if (hit) begin
                    state_d     = S_DONE;
                    timer_d     = '0;
                    win_valid_d = 1'b1;
                    win_id_d    = hit_id;
                end
            end
        endcase
    end

    always_comb begin
        best     = pos_q[0];
        leader_d = '0;
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if (pos_q[i] > best) begin
                best     = pos_q[i];
                leader_d = PID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            timer_q     <= '0;
            leader_q    <= '0;
            win_valid_q <= 1'b0;
            win_id_q    <= '0;
            auto_q      <= 1'b0;
            click_s1_q  <= '0;
            click_s2_q  <= '0;
            click_e_q   <= '0;
            tog_s1_q    <= 1'b0;
            tog_s2_q    <= 1'b0;
            tog_e_q     <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                pos_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            timer_q     <= timer_d;
            leader_q    <= leader_d;
            win_valid_q <= win_valid_d;
            win_id_q    <= win_id_d;
            auto_q      <= auto_d;
            click_s1_q  <= click_s1_d;
            click_s2_q  <= click_s2_d;
            click_e_q   <= click_e_d;
            tog_s1_q    <= tog_s1_d;
            tog_s2_q    <= tog_s2_d;
            tog_e_q     <= tog_e_d;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                pos_q[i] <= pos_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            positions[i*POS_W +: POS_W] = pos_q[i];
        end
        case (state_q)
            S_GREEN: light = 2'b01;
            S_RED:   light = 2'b10;
            default: light = 2'b00;
        endcase
        leader       = leader_q;
        winner_valid = win_valid_q;
        winner_id    = win_id_q;
        game_state   = state_q;
    end

endmodule

// File: tb/tb_rlgl_race_core.sv
// Directed bench for rlgl_race_core; three instances differ only in
// penalty mode and share all inputs.
module tb_rlgl_race_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  click = '0;
    logic        start = 1'b0;
    logic [3:0]  max_clicks = '0;
    logic        auto_light = 1'b0;
    logic        red_toggle = 1'b0;

    logic [15:0] pos_m0, pos_m1, pos_m2;
    logic [1:0]  lt_m0, lt_m1, lt_m2;
    logic [1:0]  ld_m0, ld_m1, ld_m2;
    logic        wv_m0, wv_m1, wv_m2;
    logic [1:0]  wid_m0, wid_m1, wid_m2;
    logic [1:0]  st_m0, st_m1, st_m2;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rlgl_race_core #(.GREEN_CYC(8), .RED_CYC(4), .PENALTY_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .click(click), .start(start),
        .max_clicks(max_clicks), .auto_light(auto_light),
        .red_toggle(red_toggle), .positions(pos_m0), .light(lt_m0),
        .leader(ld_m0), .winner_valid(wv_m0), .winner_id(wid_m0),
        .game_state(st_m0));

    rlgl_race_core #(.GREEN_CYC(8), .RED_CYC(4), .PENALTY_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .click(click), .start(start),
        .max_clicks(max_clicks), .auto_light(auto_light),
        .red_toggle(red_toggle), .positions(pos_m1), .light(lt_m1),
        .leader(ld_m1), .winner_valid(wv_m1), .winner_id(wid_m1),
        .game_state(st_m1));

    rlgl_race_core #(.GREEN_CYC(8), .RED_CYC(4), .PENALTY_MODE(2)) dut2 (
        .clk(clk), .rst(rst), .click(click), .start(start),
        .max_clicks(max_clicks), .auto_light(auto_light),
        .red_toggle(red_toggle), .positions(pos_m2), .light(lt_m2),
        .leader(ld_m2), .winner_valid(wv_m2), .winner_id(wid_m2),
        .game_state(st_m2));

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] pos;
        logic [1:0]  st;
        logic [1:0]  lt;
        logic [1:0]  ld;
        logic        wv;
        logic [1:0]  wid;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m);
        click = m;
        cyc(1);
        click = '0;
        cyc(4);
    endtask

    task automatic toggle();
        red_toggle = 1'b1;
        cyc(1);
        red_toggle = 1'b0;
        cyc(4);
    endtask

    task automatic start_game(input logic [3:0] m);
        max_clicks = m;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pos"}, pos_m1, 0);
        check({tag, "_light"}, lt_m1, 0);
        check({tag, "_state"}, st_m1, 0);
        check({tag, "_leader"}, ld_m1, 0);
        check({tag, "_wv"}, wv_m1, 0);
        check({tag, "_wid"}, wid_m1, 0);
    endtask

    initial begin
        tbl[0] = '{4'b0100, 16'h0100, 2'b01, 2'b01, 2'd2, 1'b0, 2'd0};
        tbl[1] = '{4'b0100, 16'h0200, 2'b01, 2'b01, 2'd2, 1'b0, 2'd0};
        tbl[2] = '{4'b0001, 16'h0201, 2'b01, 2'b01, 2'd2, 1'b0, 2'd0};
        tbl[3] = '{4'b0100, 16'h0301, 2'b11, 2'b00, 2'd2, 1'b1, 2'd2};

        cyc(3);
        rst = 1'b0;
        cyc(1);
        check_reset("rst0");

        start_game(4'd3);
        check("g1_start_state", st_m1, 2'b01);
        for (int i = 0; i < 4; i++) begin
            press(tbl[i].mask);
            check($sformatf("t%0d_pos", i), pos_m1, tbl[i].pos);
            check($sformatf("t%0d_state", i), st_m1, tbl[i].st);
            check($sformatf("t%0d_light", i), lt_m1, tbl[i].lt);
            check($sformatf("t%0d_leader", i), ld_m1, tbl[i].ld);
            check($sformatf("t%0d_wv", i), wv_m1, tbl[i].wv);
            if (tbl[i].wv) check($sformatf("t%0d_wid", i), wid_m1, tbl[i].wid);
        end

        start_game(4'd3);
        check("g2_cleared", pos_m1, 0);
        check("g2_wv_clr", wv_m1, 0);
        press(4'b0001);
        press(4'b0001);
        check("g2_pre_m0", pos_m0, 16'h0002);
        toggle();
        check("g2_red_light", lt_m1, 2'b10);
        check("g2_red_state", st_m1, 2'b10);
        press(4'b0001);
        check("pen0_pos", pos_m0, 16'h0002);
        check("pen1_pos", pos_m1, 16'h0000);
        check("pen2_pos", pos_m2, 16'h0001);
        toggle();
        check("g2_green_again", lt_m1, 2'b01);
        press(4'b1000);
        press(4'b1000);
        press(4'b1000);
        check("g2_pos_m1", pos_m1, 16'h3000);
        check("g2_done", st_m1, 2'b11);
        check("g2_wid", wid_m1, 3);
        check("g2_done_m2", st_m2, 2'b11);

        start_game(4'd2);
        press(4'b1010);
        check("tie_mid_leader", ld_m1, 1);
        press(4'b1010);
        check("tie_state", st_m1, 2'b11);
        check("tie_wv", wv_m1, 1);
        check("tie_wid", wid_m1, 1);
        press(4'b1111);
        check("tie_frozen", pos_m1, 16'h2020);
        check("tie_frozen_wid", wid_m1, 1);

        start_game(4'd15);
        click = 4'b0001;
        cyc(1);
        check("lat_k", pos_m1, 0);
        cyc(1);
        check("lat_k1", pos_m1, 0);
        cyc(1);
        check("lat_k2", pos_m1, 16'h0001);
        cyc(47);
        check("hold_once", pos_m1, 16'h0001);
        click = '0;
        cyc(4);
        check("hold_release", pos_m1, 16'h0001);
        press(4'b0010);
        check("tie_leader_low", ld_m1, 0);
        press(4'b0010);
        check("hold_pos2", pos_m1, 16'h0021);
        check("hold_leader", ld_m1, 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_reset("rst_mid");
        start_game(4'd15);
        press(4'b0010);
        check("fresh_pos", pos_m1, 16'h0010);

        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        start_game(4'd0);
        press(4'b0100);
        check("max0_state", st_m1, 2'b11);
        check("max0_wid", wid_m1, 2);
        check("max0_pos", pos_m1, 16'h0100);

        auto_light = 1'b1;
        cyc(3);
        max_clicks = 4'd15;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int c = 0; c < 24; c++) begin
            logic [1:0] exp_lt;
            if (c < 8) exp_lt = 2'b01;
            else if (c < 12) exp_lt = 2'b10;
            else if (c < 20) exp_lt = 2'b01;
            else exp_lt = 2'b10;
            check($sformatf("auto_c%0d", c), lt_m1, exp_lt);
            red_toggle = (c % 3 == 0);
            cyc(1);
        end
        red_toggle = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
